regfile_flags: RTL and testbench

REGFILE_FLAGS -- requirements
Module: regfile_flags

---
 rtl/regfile_flags.sv | 149 ++++++++++++++
 tb/tb_regfile_flags.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_flags.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_flags
//  Description : General-purpose register file with an ALU flag register and
//                a branch-condition evaluator.
//                - NREG x 8-bit registers, one synchronous write port
//                - three independent combinational read ports (a, b, monitor)
//                - 3-bit flag register {S, Z, Cy} with its own load strobe
//                - cond_true decoded from the registered flags
//
//  Ports       : clk        - clock, all state updates on the rising edge
//                reset      - synchronous, active-high; clears regs and flags
//                rs_a/rs_b  - read selects for ALU operands a_out/b_out
//                wr_en/wr_sel/wr_data - writeback port
//                flag_en/flags_in     - flag register load, {S, Z, Cy}
//                flags/cy_out         - registered flags and carry
//                cond/cond_true       - branch condition code and result
//                mon_sel/mon_data     - front-panel monitor read port
//
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_flags #(
    parameter int NREG = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [SELW-1:0] rs_a,
    input  logic [SELW-1:0] rs_b,
    output logic [7:0]      a_out,
    output logic [7:0]      b_out,

    input  logic            wr_en,
    input  logic [SELW-1:0] wr_sel,
    input  logic [7:0]      wr_data,

    input  logic            flag_en,
    input  logic [2:0]      flags_in,
    output logic [2:0]      flags,
    output logic            cy_out,

    input  logic [2:0]      cond,
    output logic            cond_true,

    input  logic [SELW-1:0] mon_sel,
    output logic [7:0]      mon_data
);

    // ------------------------------------------------------------------
    // Flag bit positions within {S, Z, Cy}
    // ------------------------------------------------------------------
    localparam int c_FLAG_CY = 0;
    localparam int c_FLAG_Z  = 1;
    localparam int c_FLAG_S  = 2;

    // ------------------------------------------------------------------
    // Branch condition encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] c_COND_ALWAYS = 3'b000;
    localparam logic [2:0] c_COND_Z      = 3'b001;
    localparam logic [2:0] c_COND_NZ     = 3'b010;
    localparam logic [2:0] c_COND_CY     = 3'b011;
    localparam logic [2:0] c_COND_NCY    = 3'b100;
    localparam logic [2:0] c_COND_S      = 3'b101;
    localparam logic [2:0] c_COND_NS     = 3'b110;
    localparam logic [2:0] c_COND_NEVER  = 3'b111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0] r_regs_q [NREG];
    logic [7:0] w_regs_d [NREG];
    logic [2:0] r_flags_q;
    logic [2:0] w_flags_d;
    logic       w_cond_true;

    // ------------------------------------------------------------------
    // Next-state: register file. Only the addressed register takes the
    // writeback value; every other register holds.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_regs_d[i] = r_regs_q[i];
            if (wr_en && (wr_sel == SELW'(i))) begin
                w_regs_d[i] = wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: flag register, independent of the writeback strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_flags_d = r_flags_q;
        if (flag_en) begin
            w_flags_d = flags_in;
        end
    end

    // ------------------------------------------------------------------
    // Sequential update. Reset wins over both strobes in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs_q[i] <= 8'h00;
            end
            r_flags_q <= 3'b000;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_regs_q[i] <= w_regs_d[i];
            end
            r_flags_q <= w_flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Branch condition, decoded from the registered flags only so that a
    // branch sees the result of the previously completed ALU operation.
    // ------------------------------------------------------------------
    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            c_COND_ALWAYS: w_cond_true = 1'b1;
            c_COND_Z:      w_cond_true =  r_flags_q[c_FLAG_Z];
            c_COND_NZ:     w_cond_true = ~r_flags_q[c_FLAG_Z];
            c_COND_CY:     w_cond_true =  r_flags_q[c_FLAG_CY];
            c_COND_NCY:    w_cond_true = ~r_flags_q[c_FLAG_CY];
            c_COND_S:      w_cond_true =  r_flags_q[c_FLAG_S];
            c_COND_NS:     w_cond_true = ~r_flags_q[c_FLAG_S];
            c_COND_NEVER:  w_cond_true = 1'b0;
            default:       w_cond_true = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Reads come straight from the register array with no write
    // bypass: a register being written shows its old value until the edge.
    // ------------------------------------------------------------------
    assign a_out     = r_regs_q[rs_a];
    assign b_out     = r_regs_q[rs_b];
    assign mon_data  = r_regs_q[mon_sel];
    assign flags     = r_flags_q;
    assign cy_out    = r_flags_q[c_FLAG_CY];
    assign cond_true = w_cond_true;

endmodule
`default_nettype wire

// File: tb/tb_regfile_flags.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_flags
//  Description : Self-checking bench for regfile_flags. Directed scenarios
//                followed by randomized traffic, all checked against a
//                behavioural model of the register file and flag register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_flags;

    localparam int NREG = 4;
    localparam int SELW = 2;

    logic            clk;
    logic            reset;
    logic [SELW-1:0] rs_a;
    logic [SELW-1:0] rs_b;
    logic [7:0]      a_out;
    logic [7:0]      b_out;
    logic            wr_en;
    logic [SELW-1:0] wr_sel;
    logic [7:0]      wr_data;
    logic            flag_en;
    logic [2:0]      flags_in;
    logic [2:0]      flags;
    logic            cy_out;
    logic [2:0]      cond;
    logic            cond_true;
    logic [SELW-1:0] mon_sel;
    logic [7:0]      mon_data;

    regfile_flags #(
        .NREG (NREG),
        .SELW (SELW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_a      (rs_a),
        .rs_b      (rs_b),
        .a_out     (a_out),
        .b_out     (b_out),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .flag_en   (flag_en),
        .flags_in  (flags_in),
        .flags     (flags),
        .cy_out    (cy_out),
        .cond      (cond),
        .cond_true (cond_true),
        .mon_sel   (mon_sel),
        .mon_data  (mon_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: plain array of register values plus a flag word
    // ------------------------------------------------------------------
    logic [7:0] mdl_regs [NREG];
    logic [2:0] mdl_flags;

    int vectors = 0;
    int errors  = 0;

    // Branch table: flags are {S, Z, Cy}
    function automatic logic cond_ref(input logic [2:0] f, input logic [2:0] c);
        logic s, z, cy;
        s  = f[2];
        z  = f[1];
        cy = f[0];
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return cy;
            3'd4:    return !cy;
            3'd5:    return s;
            3'd6:    return !s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the current selects
    task automatic check_all(input string tag);
        check({tag, ".a_out"},     a_out,           mdl_regs[rs_a]);
        check({tag, ".b_out"},     b_out,           mdl_regs[rs_b]);
        check({tag, ".mon_data"},  mon_data,        mdl_regs[mon_sel]);
        check({tag, ".flags"},     {5'd0, flags},   {5'd0, mdl_flags});
        check({tag, ".cy_out"},    {7'd0, cy_out},  {7'd0, mdl_flags[0]});
        check({tag, ".cond_true"}, {7'd0, cond_true},
              {7'd0, cond_ref(mdl_flags, cond)});
    endtask

    // Advance one clock edge, updating the model with the applied inputs
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREG; i++) mdl_regs[i] = 8'h00;
            mdl_flags = 3'b000;
        end else begin
            if (wr_en)   mdl_regs[wr_sel] = wr_data;
            if (flag_en) mdl_flags = flags_in;
        end
        #1;
    endtask

    task automatic write_reg(input logic [SELW-1:0] sel, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    logic [8:0] alu_sum;
    logic [2:0] cond_exp [7];

    initial begin
        reset = 1'b0; rs_a = '0; rs_b = '0; mon_sel = '0;
        wr_en = 1'b0; wr_sel = '0; wr_data = 8'h00;
        flag_en = 1'b0; flags_in = 3'b000; cond = 3'b000;
        for (int i = 0; i < NREG; i++) mdl_regs[i] = 8'h00;
        mdl_flags = 3'b000;

        // ---- Reset state --------------------------------------------
        @(negedge clk);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rs_a = 2'd0; rs_b = 2'd3; mon_sel = 2'd2; cond = 3'b000;
        #1;
        check("rst.a_out", a_out, 8'h00);
        check("rst.b_out", b_out, 8'h00);
        check("rst.mon", mon_data, 8'h00);
        check("rst.flags", {5'd0, flags}, 8'h00);
        check("rst.cy", {7'd0, cy_out}, 8'h00);
        check("rst.cond0", {7'd0, cond_true}, 8'h01);
        cond = 3'b111;
        #1;
        check("rst.cond7", {7'd0, cond_true}, 8'h00);

        // ---- Write without bypass ------------------------------------
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'hA5; rs_a = 2'd1;
        #1;
        check("wr.pre_edge", a_out, 8'h00);
        step();
        wr_en = 1'b0;
        #1;
        check("wr.post_edge", a_out, 8'hA5);
        mon_sel = 2'd0; #1; check("wr.r0_hold", mon_data, 8'h00);
        mon_sel = 2'd2; #1; check("wr.r2_hold", mon_data, 8'h00);
        mon_sel = 2'd3; #1; check("wr.r3_hold", mon_data, 8'h00);

        // ---- Flag load and branch table --------------------------------
        flag_en = 1'b1; flags_in = 3'b011;
        step();
        flag_en = 1'b0;
        flags_in = 3'b100;  // cy_out must ignore the unregistered input
        #1;
        check("flg.flags", {5'd0, flags}, 8'h03);
        check("flg.cy", {7'd0, cy_out}, 8'h01);
        cond_exp[1] = 3'd1; cond_exp[2] = 3'd0; cond_exp[3] = 3'd1;
        cond_exp[4] = 3'd0; cond_exp[5] = 3'd0; cond_exp[6] = 3'd1;
        for (int c = 1; c <= 6; c++) begin
            cond = 3'(c);
            #1;
            check($sformatf("flg.cond%0d", c), {7'd0, cond_true}, {5'd0, cond_exp[c]});
        end

        // ---- Reset priority over both strobes -------------------------
        reset = 1'b1; wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'hFF;
        flag_en = 1'b1; flags_in = 3'b111;
        step();
        reset = 1'b0; wr_en = 1'b0; flag_en = 1'b0;
        mon_sel = 2'd2; rs_a = 2'd1;
        #1;
        check("rstp.r2", mon_data, 8'h00);
        check("rstp.r1", a_out, 8'h00);
        check("rstp.flags", {5'd0, flags}, 8'h00);

        // ---- Consecutive writes, shared selects, last write wins -------
        write_reg(2'd0, 8'h11);
        write_reg(2'd1, 8'h22);
        write_reg(2'd2, 8'h33);
        write_reg(2'd3, 8'h44);
        rs_a = 2'd2; rs_b = 2'd2; mon_sel = 2'd2;
        #1;
        check("same.a", a_out, 8'h33);
        check("same.b", b_out, 8'h33);
        check("same.mon", mon_data, 8'h33);
        write_reg(2'd2, 8'h55);
        check("b2b.first", a_out, 8'h55);
        write_reg(2'd2, 8'h66);
        check("b2b.a", a_out, 8'h66);
        check("b2b.mon", mon_data, 8'h66);
        cond = 3'b000;
        check_all("seq");

        // ---- ALU loop: a + b + Cy written back with flags --------------
        write_reg(2'd0, 8'hFF);
        write_reg(2'd1, 8'h01);
        rs_a = 2'd0; rs_b = 2'd1; mon_sel = 2'd2;
        for (int pass = 0; pass < 2; pass++) begin
            #1;
            check($sformatf("alu%0d.cy_in", pass), {7'd0, cy_out}, 8'(pass));
            alu_sum  = {1'b0, a_out} + {1'b0, b_out} + {8'd0, cy_out};
            wr_en    = 1'b1; wr_sel = 2'd2; wr_data = alu_sum[7:0];
            flag_en  = 1'b1;
            flags_in = {alu_sum[7], alu_sum[7:0] == 8'h00, alu_sum[8]};
            step();
            wr_en = 1'b0; flag_en = 1'b0;
            #1;
            check($sformatf("alu%0d.r2", pass), mon_data, (pass == 0) ? 8'h00 : 8'h01);
            check($sformatf("alu%0d.flags", pass), {5'd0, flags},
                  (pass == 0) ? 8'h03 : 8'h01);
        end

        // ---- Randomized traffic against the model ---------------------
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 31) == 0);
            wr_en    = 1'($urandom);
            wr_sel   = SELW'($urandom);
            wr_data  = 8'($urandom);
            flag_en  = 1'($urandom);
            flags_in = 3'($urandom);
            rs_a     = SELW'($urandom);
            rs_b     = SELW'($urandom);
            mon_sel  = SELW'($urandom);
            cond     = 3'($urandom);
            #1;
            check_all($sformatf("rnd%0d", n));
            step();
        end
        reset = 1'b0; wr_en = 1'b0; flag_en = 1'b0;
        #1;
        check_all("rnd.final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
